// File: rtl/matrix_pkg.sv
// Shared types and constants for the sequential matrix add/subtract block.
package matrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int unsigned MIN_N = 2;

endpackage

// File: rtl/matrix_elem_addsub.sv
// One signed element add/subtract lane with overflow detect and optional clamp.
module matrix_elem_addsub
  import matrix_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              mode,
  input  logic              saturate,
  output logic [DATA_W-1:0] y,
  output logic              ovf
);

  logic [DATA_W:0] a_x;
  logic [DATA_W:0] b_x;
  logic [DATA_W:0] sum;

  // One extra bit holds the true sign; overflow when it disagrees with the stored MSB.
  always_comb begin
    a_x = {a[DATA_W-1], a};
    b_x = {b[DATA_W-1], b};
    sum = (mode == MODE_SUB) ? (a_x - b_x) : (a_x + b_x);
    ovf = sum[DATA_W] ^ sum[DATA_W-1];
    y   = sum[DATA_W-1:0];
    if (ovf && saturate) begin
      y = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/matrix_addsub_seq.sv
// Row-at-a-time N x N signed matrix add/subtract with wrap or saturate.
module matrix_addsub_seq
  import matrix_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_N  = 5
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            mode,
  input  logic                            saturate,
  input  logic [2:0]                      matrix_size,
  input  logic [MAX_N*MAX_N*DATA_W-1:0]   matrix_A,
  input  logic [MAX_N*MAX_N*DATA_W-1:0]   matrix_B,
  output logic [MAX_N*MAX_N*DATA_W-1:0]   result_out,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow,
  output logic                            error
);

  localparam int unsigned VEC_W = MAX_N * MAX_N * DATA_W;

  state_t            state_q, state_d;
  logic [2:0]        row_q, row_d;
  logic [2:0]        n_q, n_d;
  logic              mode_q, mode_d;
  logic              sat_q, sat_d;
  logic [VEC_W-1:0]  a_q, a_d;
  logic [VEC_W-1:0]  b_q, b_d;
  logic [VEC_W-1:0]  res_q, res_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  logic              size_ok_c;

  logic [DATA_W-1:0] lane_a   [MAX_N];
  logic [DATA_W-1:0] lane_b   [MAX_N];
  logic [DATA_W-1:0] lane_y   [MAX_N];
  logic              lane_ovf [MAX_N];

  // Legal dimension check on the live size input.
  always_comb begin
    size_ok_c = (32'(matrix_size) >= MIN_N) && (32'(matrix_size) <= MAX_N);
  end

  // Route the current row's captured operands to the lanes; lane c handles column c.
  always_comb begin
    int unsigned idx;
    for (int unsigned c = 0; c < MAX_N; c++) begin
      idx       = 32'(row_q) * 32'(n_q) + c;
      lane_a[c] = a_q[idx*DATA_W +: DATA_W];
      lane_b[c] = b_q[idx*DATA_W +: DATA_W];
    end
  end

  for (genvar g = 0; g < MAX_N; g++) begin : g_lane
    matrix_elem_addsub #(.DATA_W(DATA_W)) u_elem (
      .a        (lane_a[g]),
      .b        (lane_b[g]),
      .mode     (mode_q),
      .saturate (sat_q),
      .y        (lane_y[g]),
      .ovf      (lane_ovf[g])
    );
  end

  // Next-state and next-register values.
  always_comb begin
    int unsigned idx;
    state_d = state_q;
    row_d   = row_q;
    n_d     = n_q;
    mode_d  = mode_q;
    sat_d   = sat_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    err_d   = err_q;
    idx     = 0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          res_d = '0;
          ovf_d = 1'b0;
          row_d = 3'd0;
          if (size_ok_c) begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
            a_d     = matrix_A;
            b_d     = matrix_B;
            mode_d  = mode;
            sat_d   = saturate;
            n_d     = matrix_size;
            err_d   = 1'b0;
          end else begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end

      ST_RUN: begin
        for (int unsigned c = 0; c < MAX_N; c++) begin
          if (c < 32'(n_q)) begin
            idx = 32'(row_q) * 32'(n_q) + c;
            res_d[idx*DATA_W +: DATA_W] = lane_y[c];
            ovf_d = ovf_d | lane_ovf[c];
          end
        end
        if (row_q == n_q - 3'd1) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          row_d   = 3'd0;
        end else begin
          row_d = row_q + 3'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q  <= 3'd0;
      n_q    <= 3'd0;
      mode_q <= MODE_ADD;
      sat_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      row_q  <= row_d;
      n_q    <= n_d;
      mode_q <= mode_d;
      sat_q  <= sat_d;
      a_q    <= a_d;
      b_q    <= b_d;
      res_q  <= res_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
      err_q  <= err_d;
    end
  end

  assign result_out = res_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign error      = err_q;

endmodule

// File: tb/tb_matrix_addsub_seq.sv
// Scoreboard bench for matrix_addsub_seq: random and directed operations vs. an arithmetic model.
module tb_matrix_addsub_seq;

  localparam int DW   = 8;
  localparam int MN   = 5;
  localparam int TOT  = MN * MN * DW;
  localparam int MAXV = 2 ** (DW - 1) - 1;
  localparam int MINV = -(2 ** (DW - 1));

  logic           clk;
  logic           reset;
  logic           start;
  logic           mode;
  logic           saturate;
  logic [2:0]     matrix_size;
  logic [TOT-1:0] matrix_A;
  logic [TOT-1:0] matrix_B;
  logic [TOT-1:0] result_out;
  logic           busy;
  logic           done;
  logic           overflow;
  logic           error;

  matrix_addsub_seq #(.DATA_W(DW), .MAX_N(MN)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .saturate    (saturate),
    .matrix_size (matrix_size),
    .matrix_A    (matrix_A),
    .matrix_B    (matrix_B),
    .result_out  (result_out),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [TOT-1:0] res;
    logic           ovf;
    logic           err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk_bit(string name, logic act, logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic chk_vec(string name, logic [TOT-1:0] act, logic [TOT-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic per element, then wrap or clamp to DW bits.
  function automatic exp_t model(logic [TOT-1:0] A, logic [TOT-1:0] B, logic m, logic s, int n);
    exp_t e;
    int a, b, t;
    e.res = '0;
    e.ovf = 1'b0;
    e.err = 1'b0;
    if (n < 2 || n > MN) begin
      e.err = 1'b1;
      return e;
    end
    for (int i = 0; i < n * n; i++) begin
      a = int'($signed(A[i*DW +: DW]));
      b = int'($signed(B[i*DW +: DW]));
      t = m ? (a - b) : (a + b);
      if (t > MAXV || t < MINV) begin
        e.ovf = 1'b1;
        if (s) t = (t > MAXV) ? MAXV : MINV;
      end
      e.res[i*DW +: DW] = t[DW-1:0];
    end
    return e;
  endfunction

  function automatic logic [TOT-1:0] rand_vec();
    logic [TOT-1:0] v;
    for (int i = 0; i < TOT; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic logic [TOT-1:0] fill(int val);
    logic [TOT-1:0] v;
    for (int i = 0; i < MN * MN; i++) v[i*DW +: DW] = val[DW-1:0];
    return v;
  endfunction

  // Drive a start request at the current negedge; optionally queue its expected response.
  task automatic issue(input logic m, input logic s, input int n, input logic [TOT-1:0] A,
                       input logic [TOT-1:0] B, input bit push, output exp_t e);
    mode        = m;
    saturate    = s;
    matrix_size = 3'(n);
    matrix_A    = A;
    matrix_B    = B;
    start       = 1'b1;
    e = model(A, B, m, s, n);
    if (push) exp_q.push_back(e);
  endtask

  // Follow an accepted start cycle by cycle, checking busy/done timing; returns at the done cycle.
  task automatic track(input int n, input bit legal, input int glitch);
    int last;
    last = legal ? n + 1 : 1;
    for (int i = 1; i <= last; i++) begin
      @(negedge clk);
      chk_bit($sformatf("busy_n%0d_c%0d", n, i), busy, legal && (i <= n));
      chk_bit($sformatf("done_n%0d_c%0d", n, i), done, i == last);
      start    = 1'b0;
      matrix_A = rand_vec();
      matrix_B = rand_vec();
      if (i == glitch) begin
        start       = 1'b1;
        mode        = ~mode;
        matrix_size = 3'd2;
      end
    end
  endtask

  task automatic hold_check(input exp_t e);
    @(negedge clk);
    chk_bit("hold_done", done, 1'b0);
    chk_vec("hold_result", result_out, e.res);
    chk_bit("hold_overflow", overflow, e.ovf);
    chk_bit("hold_error", error, e.err);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation");
      end else begin
        mon_e = exp_q.pop_front();
        chk_vec("result", result_out, mon_e.res);
        chk_bit("overflow", overflow, mon_e.ovf);
        chk_bit("error", error, mon_e.err);
        chk_bit("busy_at_done", busy, 1'b0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [TOT-1:0] va, vb;
    int n;
    bit legal;

    reset = 1'b1; start = 1'b0; mode = 1'b0; saturate = 1'b0;
    matrix_size = 3'd0; matrix_A = '0; matrix_B = '0;
    repeat (2) @(negedge clk);
    chk_vec("reset_result", result_out, '0);
    chk_bit("reset_busy", busy, 1'b0);
    chk_bit("reset_done", done, 1'b0);
    chk_bit("reset_overflow", overflow, 1'b0);
    chk_bit("reset_error", error, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // N=2 subtract, wrap then saturate
    va = rand_vec(); vb = rand_vec();
    va[0 +: 8] = 8'd10; va[8 +: 8] = 8'hFB; va[16 +: 8] = 8'h7F; va[24 +: 8] = 8'h80;
    vb[0 +: 8] = 8'd3;  vb[8 +: 8] = 8'd5;  vb[16 +: 8] = 8'hFF; vb[24 +: 8] = 8'd1;
    for (int s = 0; s < 2; s++) begin
      issue(1'b1, 1'(s), 2, va, vb, 1'b1, e);
      track(2, 1'b1, 0);
      hold_check(e);
    end

    // N=3 add of constants, exact max then wrap
    issue(1'b0, 1'b0, 3, fill(100), fill(27), 1'b1, e);
    track(3, 1'b1, 0);
    hold_check(e);
    issue(1'b0, 1'b0, 3, fill(100), fill(28), 1'b1, e);
    track(3, 1'b1, 0);
    hold_check(e);

    // N=5 with a start glitch during RUN, then back-to-back start in the DONE cycle
    issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5, rand_vec(), rand_vec(), 1'b1, e);
    track(5, 1'b1, 2);
    issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4, rand_vec(), rand_vec(), 1'b1, e);
    track(4, 1'b1, 0);
    hold_check(e);

    // Reset in the middle of an N=5 run
    issue(1'b0, 1'b0, 5, fill(100), fill(100), 1'b0, e);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk_bit("pre_reset_busy", busy, 1'b1);
    chk_bit("pre_reset_overflow", overflow, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_bit("mid_reset_busy", busy, 1'b0);
    chk_bit("mid_reset_done", done, 1'b0);
    chk_bit("mid_reset_overflow", overflow, 1'b0);
    chk_vec("mid_reset_result", result_out, '0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk_bit("post_reset_no_done", done, 1'b0);
    end

    // Illegal sizes after a legal run that leaves nonzero state
    issue(1'b0, 1'b0, 3, fill(100), fill(28), 1'b1, e);
    track(3, 1'b1, 0);
    hold_check(e);
    issue(1'b0, 1'b0, 1, rand_vec(), rand_vec(), 1'b1, e);
    track(1, 1'b0, 0);
    hold_check(e);
    issue(1'b1, 1'b1, 6, rand_vec(), rand_vec(), 1'b1, e);
    track(6, 1'b0, 0);
    hold_check(e);

    // Randomized operations with occasional illegal sizes and back-to-back starts
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) n = int'($urandom_range(0, 3)) * 2 % 8 + (($urandom_range(0, 1) == 1) ? 1 : 0);
      else n = int'($urandom_range(2, MN));
      if (n > 7) n = 7;
      legal = (n >= 2 && n <= MN);
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n, rand_vec(), rand_vec(), 1'b1, e);
      track(n, legal, 0);
      if ($urandom_range(0, 2) != 0) begin
        hold_check(e);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    checks++;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_addsub_seq.md
MATRIX_ADDSUB_SEQ -- requirements
Module: matrix_addsub_seq

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning signed element width in bits.
REQ-002 The block SHALL have parameter MAX_N, default 5, meaning the largest supported square dimension (legal range 2..7).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port reset  input  1  synchronous active-high reset.
REQ-006 Port start  input  1  request to begin an operation; sampled only in IDLE or DONE.
REQ-007 Port mode  input  1  0 = A+B, 1 = A-B; captured at start.
REQ-008 Port saturate  input  1  0 = wrap, 1 = clamp on overflow; captured at start.
REQ-009 Port matrix_size  input  3  dimension N, legal 2..MAX_N; captured at start.
REQ-010 Port matrix_A  input  MAX_N*MAX_N*DATA_W  signed operand; element i = r*N+c at [i*DATA_W +: DATA_W].
REQ-011 Port matrix_B  input  MAX_N*MAX_N*DATA_W  signed operand, same packing.
REQ-012 Port result_out  output  MAX_N*MAX_N*DATA_W  registered result, same packing.
REQ-013 Port busy  output  1  high while rows are being processed.
REQ-014 Port done  output  1  one-cycle pulse at operation end.
REQ-015 Port overflow  output  1  sticky OR of element overflows of the current operation.
REQ-016 Port error  output  1  illegal matrix_size at the accepted start.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-018 start=1 in IDLE or DONE with legal size SHALL latch operands, mode, saturate, N; clear result_out, overflow, error; set row=0; enter RUN.
REQ-019 start while in RUN SHALL be ignored.
REQ-020 Each RUN cycle SHALL compute row `row` (N elements, indices row*N..row*N+N-1), write them into result_out, increment row.
REQ-021 When row==N-1, the next state SHALL be DONE; busy SHALL be high for exactly N cycles, done high on cycle N+1 after the start edge.
REQ-022 Add overflow: operands same sign and result sign differs; sub overflow: operand signs differ and result sign differs from A.
REQ-023 saturate=0 SHALL store the low DATA_W bits; saturate=1 SHALL store +2^(DATA_W-1)-1 or -2^(DATA_W-1) per true result sign on overflow.
REQ-024 overflow SHALL be set on any overflowing element of the active region regardless of saturate, and held until the next accepted start or reset.
REQ-025 Element positions >= N*N SHALL read zero.
REQ-026 result_out, overflow, error SHALL hold their values from DONE through IDLE until the next accepted start.
REQ-027 start with matrix_size <2 or >MAX_N SHALL skip RUN, enter DONE next cycle with error=1, result_out=0, overflow=0.
REQ-028 Operand inputs SHALL be ignored after the start edge (captured copy used).

Reset
REQ-029 reset=1 at any edge, including mid-RUN, SHALL force IDLE, row=0, result_out=0, busy=0, done=0, overflow=0, error=0; reset has priority over start.

Structure
REQ-030 Package matrix_pkg SHALL hold the FSM state enum, mode encodings (MODE_ADD, MODE_SUB), and MIN_N=2.
REQ-031 Sub-module matrix_elem_addsub (combinational: a, b, mode, saturate -> y, ovf) SHALL be instantiated MAX_N times, one per row lane.

Verification (DATA_W=8, MAX_N=5)
REQ-032 N=2 sub, A={10,-5,127,-128}, B={3,5,-1,1}, saturate=0 -> result {7,-10,-128,127}, overflow=1, done 3 cycles after start, busy 2 cycles.
REQ-033 Same stimulus, saturate=1 -> result {7,-10,127,-128}, overflow=1.
REQ-034 N=3 add, all A=100, B=27 -> elements 0..8 =127, 9..24 =0, overflow=0, done 4 cycles after start; repeat with B=28 -> 9 elements -128 (wrap), overflow=1.
REQ-035 N=5 run: start pulsed again in RUN cycle 2 -> ignored, done once at cycle 6; start asserted in the DONE cycle -> new run begins, busy high next cycle.
REQ-036 reset asserted at RUN cycle 2 of N=5 -> next cycle busy=0, done=0, overflow=0, result_out=0, no done pulse follows.
REQ-037 matrix_size=1 and matrix_size=6 -> error=1, done pulse next cycle, busy never high, result_out=0.
